// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU MEM
// stage (port 0) and the vector/DMA loader (port 1), with fixed memory latency.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_flush,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_done_q, cpu_done_d;
  logic                ld_done_q, ld_done_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;

  logic c_elig, l_elig, grant_ld;

  // The done masks stop a requester that still holds req in its done cycle
  // from being granted a second time.
  assign c_elig   = cpu_req & ~cpu_flush & ~cpu_done_q;
  assign l_elig   = ld_req & ~ld_done_q;
  assign grant_ld = l_elig & (~c_elig | rr_q);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_done_d  = 1'b0;
    ld_done_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (c_elig || l_elig) begin
          mem_en_d    = 1'b1;
          owner_d     = grant_ld;
          mem_we_d    = grant_ld ? ld_we    : cpu_we;
          mem_addr_d  = grant_ld ? ld_addr  : cpu_addr;
          mem_wdata_d = grant_ld ? ld_wdata : cpu_wdata;
          cnt_d       = CNT_W'(MEM_LAT);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q) begin
            ld_done_d = 1'b1;
            if (!mem_we_q) ld_rdata_d = mem_rdata;
          end else begin
            cpu_done_d = 1'b1;
            if (!mem_we_q) cpu_rdata_d = mem_rdata;
          end
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_done_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_done_q  <= cpu_done_d;
      ld_done_q   <= ld_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_done  = cpu_done_q;
  assign ld_done   = ld_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: MEM_LAT=2 instance with a one-stage
// memory model, plus a MEM_LAT=1 instance with a combinational memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // MEM_LAT = 2 instance
  logic        cpu_req = 0, cpu_we = 0, cpu_flush = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_done, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ld_req = 0, ld_we = 0;
  logic [31:0] ld_addr = 0, ld_wdata = 0;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'hBAD0_BAD0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_flush(cpu_flush), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data is valid only for the edge MEM_LAT cycles after the mem_en edge.
  always @(posedge clk) mem_rdata <= mem_en ? mem_fn(mem_addr) : 32'hBAD0_BAD0;

  // MEM_LAT = 1 instance
  logic        c1_req = 0, c1_we = 0, c1_flush = 0;
  logic [31:0] c1_addr = 0, c1_wdata = 0;
  logic        c1_done, c1_stall;
  logic [31:0] c1_rdata;
  logic        l1_req = 0, l1_we = 0;
  logic [31:0] l1_addr = 0, l1_wdata = 0;
  logic        l1_done;
  logic [31:0] l1_rdata;
  logic        m1_en, m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_flush(c1_flush), .cpu_done(c1_done), .cpu_rdata(c1_rdata), .cpu_stall(c1_stall),
    .ld_req(l1_req), .ld_we(l1_we), .ld_addr(l1_addr), .ld_wdata(l1_wdata),
    .ld_done(l1_done), .ld_rdata(l1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata)
  );

  assign m1_rdata = m1_en ? mem_fn(m1_addr) : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned w;
    logic        exp_ld;

    // Reset state
    tick; tick;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ld_rdata", ld_rdata, 0);
    reset = 1'b1;
    tick;

    // 1: CPU read 0x100
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    #1 chk("t1_stall_req", cpu_stall, 1);
    tick;
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_stall_a", cpu_stall, 1);
    tick;
    chk("t1_mem_en_drop", mem_en, 0);
    chk("t1_done_early", cpu_done, 0);
    chk("t1_stall_b", cpu_stall, 1);
    tick;
    chk("t1_done", cpu_done, 1);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_stall_done", cpu_stall, 0);
    cpu_req = 0;
    tick;
    chk("t1_done_pulse", cpu_done, 0);
    chk("t1_rdata_held", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_no_regrant", mem_en, 0);

    // 2: simultaneous requests after reset, CPU wins
    reset = 0; #1; reset = 1;
    cpu_req = 1; cpu_addr = 32'h200;
    ld_req = 1; ld_we = 0; ld_addr = 32'h300;
    tick;
    chk("t2_cpu_first", mem_addr, 32'h200);
    chk("t2_mem_en_c", mem_en, 1);
    tick; tick;
    chk("t2_cpu_done", cpu_done, 1);
    chk("t2_cpu_rdata", cpu_rdata, 32'h5A5A_0200);
    chk("t2_ld_wait", ld_done, 0);
    cpu_req = 0;
    tick;
    chk("t2_ld_mem_en", mem_en, 1);
    chk("t2_ld_addr", mem_addr, 32'h300);
    tick; tick;
    chk("t2_ld_done", ld_done, 1);
    chk("t2_ld_rdata", ld_rdata, 32'h5A5A_0300);
    chk("t2_cpu_quiet", cpu_done, 0);

    // 3: continuous requests alternate C,L,C,L...
    cpu_addr = 32'h400; cpu_req = 1;
    ld_addr = 32'h500;
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (!mem_en && w < 4) begin
        tick;
        w++;
      end
      chk("t3_grant_seen", mem_en, 1);
      if (i > 0) chk("t3_gap", w, 1);
      exp_ld = (i % 2) == 1;
      chk("t3_owner_addr", mem_addr, exp_ld ? 32'h500 : 32'h400);
      tick; tick;
      chk("t3_cpu_done", cpu_done, !exp_ld);
      chk("t3_ld_done", ld_done, exp_ld);
    end
    cpu_req = 0; ld_req = 0;
    tick;

    // 4: flush masks a CPU request in IDLE but not an in-flight access
    cpu_req = 1; cpu_flush = 1; cpu_we = 0; cpu_addr = 32'h600;
    #1 chk("t4_stall", cpu_stall, 1);
    tick;
    chk("t4_flush_blocks", mem_en, 0);
    cpu_flush = 0;
    tick;
    chk("t4_grant", mem_en, 1);
    chk("t4_addr", mem_addr, 32'h600);
    cpu_flush = 1;
    tick;
    chk("t4_busy_nodone", cpu_done, 0);
    tick;
    chk("t4_done", cpu_done, 1);
    chk("t4_rdata", cpu_rdata, 32'h5A5A_0600);
    cpu_flush = 0; cpu_req = 0;
    tick;
    chk("t4_idle", mem_en, 0);

    // 5: loader write 0x55 to 0x20
    ld_req = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'h55;
    tick;
    chk("t5_en", mem_en, 1);
    chk("t5_we", mem_we, 1);
    chk("t5_addr", mem_addr, 32'h20);
    chk("t5_wdata", mem_wdata, 32'h55);
    tick;
    chk("t5_en_drop", mem_en, 0);
    chk("t5_we_held", mem_we, 1);
    chk("t5_wdata_held", mem_wdata, 32'h55);
    chk("t5_addr_held", mem_addr, 32'h20);
    tick;
    chk("t5_done", ld_done, 1);
    chk("t5_rdata_kept", ld_rdata, 32'h5A5A_0500);
    ld_req = 0; ld_we = 0;
    tick;
    chk("t5_done_pulse", ld_done, 0);

    // 6: reset mid-BUSY
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h700; cpu_wdata = 32'h1234;
    tick;
    chk("t6_grant", mem_en, 1);
    reset = 0;
    #1;
    chk("t6_rst_en", mem_en, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_cpu_rdata", cpu_rdata, 0);
    chk("t6_rst_ld_rdata", ld_rdata, 0);
    cpu_req = 0;
    tick;
    reset = 1;
    tick;
    chk("t6_no_done_a", cpu_done, 0);
    tick;
    chk("t6_no_done_b", cpu_done, 0);
    chk("t6_no_en", mem_en, 0);
    cpu_req = 1; cpu_addr = 32'h100;
    tick;
    chk("t6_fresh_grant", mem_en, 1);
    tick; tick;
    chk("t6_fresh_done", cpu_done, 1);
    chk("t6_fresh_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 0;
    tick;

    // 7: MEM_LAT=1 instance
    c1_req = 1; c1_addr = 32'h100;
    l1_req = 1; l1_addr = 32'h300;
    tick;
    chk("t7_cpu_en", m1_en, 1);
    chk("t7_cpu_addr", m1_addr, 32'h100);
    tick;
    chk("t7_cpu_done", c1_done, 1);
    chk("t7_cpu_rdata", c1_rdata, 32'hDEAD_BEEF);
    chk("t7_en_drop", m1_en, 0);
    c1_req = 0;
    tick;
    chk("t7_ld_en", m1_en, 1);
    chk("t7_ld_addr", m1_addr, 32'h300);
    tick;
    chk("t7_ld_done", l1_done, 1);
    chk("t7_ld_rdata", l1_rdata, 32'h5A5A_0300);
    l1_req = 0;
    tick;
    chk("t7_ld_pulse", l1_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
